// File: rtl/inst_bus_pkg.sv
// Shared types and constants for the instruction-fetch bus router.
// Covers the FSM state encoding and the default two-slave address map.
package inst_bus_pkg;

    localparam int ADDR_W     = 32;
    localparam int MAX_SLAVES = 8;

    // Default map: slave 0 = SRAM at 0x00000000 (8 MB), slave 1 = boot ROM at 0x1FC00000 (1 MB)
    localparam logic [2*ADDR_W-1:0] DEFAULT_BASE = {32'h1FC00000, 32'h00000000};
    localparam logic [2*ADDR_W-1:0] DEFAULT_MASK = {32'hFFF00000, 32'hFF800000};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_t;

endpackage

// File: rtl/inst_bus_decoder.sv
// Address window decoder: priority-encodes the fetch address against the
// per-slave base/mask windows. When windows overlap, the lowest index wins.
module inst_bus_decoder
    import inst_bus_pkg::*;
#(
    parameter int                         NUM_SLAVES = 2,
    parameter int                         IDX_W      = 1,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEFAULT_MASK
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic                  hit,
    output logic [NUM_SLAVES-1:0] sel,
    output logic [IDX_W-1:0]      idx
);

    // Scan from the highest index down so the lowest matching window is the one left standing
    always_comb begin
        hit = 1'b0;
        sel = '0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/inst_bus_router.sv
// Instruction-fetch bus router: decodes the fetch address, runs a req/ack access
// with one read-only slave, returns the word and reports unmapped/timeout errors.
module inst_bus_router
    import inst_bus_pkg::*;
#(
    parameter int                           NUM_SLAVES = 2,
    parameter int                           DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEFAULT_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEFAULT_MASK,
    parameter int                           TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            mmu_output_address,
    input  logic                         inst_req,
    output logic                         inst_ready,
    output logic [DATA_W-1:0]            inst_data,
    output logic                         inst_bus_error,
    output logic                         inst_stall,
    output logic [NUM_SLAVES-1:0]        dev_sel,
    output logic [ADDR_W-1:0]            dev_address,
    input  logic [NUM_SLAVES*DATA_W-1:0] dev_rdata,
    input  logic [NUM_SLAVES-1:0]        dev_ack
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bus_state_t             state, state_next;
    logic                   dec_hit;
    logic [NUM_SLAVES-1:0]  dec_sel;
    logic [IDX_W-1:0]       dec_idx;
    logic [IDX_W-1:0]       sel_idx;
    logic [CNT_W-1:0]       cnt;
    logic                   err;
    logic                   flushed;
    logic                   sel_ack;
    logic                   timed_out;
    logic [DATA_W-1:0]      sel_rdata;

    inst_bus_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .addr (mmu_output_address),
        .hit  (dec_hit),
        .sel  (dec_sel),
        .idx  (dec_idx)
    );

    // Only the latched slave's ack and data are looked at; other channels are ignored
    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_ack   = dev_ack[i];
                sel_rdata = dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (inst_req) begin
                    state_next = dec_hit ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (sel_ack || timed_out) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A request dropped during WAIT marks the access as flushed so its response is swallowed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_sel     <= '0;
            dev_address <= '0;
            inst_data   <= '0;
            sel_idx     <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            flushed     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req) begin
                        flushed <= 1'b0;
                        if (dec_hit) begin
                            dev_address <= mmu_output_address;
                            dev_sel     <= dec_sel;
                            sel_idx     <= dec_idx;
                            cnt         <= '0;
                        end else begin
                            inst_data <= '0;
                            err       <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!inst_req) begin
                        flushed <= 1'b1;
                    end
                    if (sel_ack) begin
                        inst_data <= sel_rdata;
                        err       <= 1'b0;
                        dev_sel   <= '0;
                    end else if (timed_out) begin
                        inst_data <= '0;
                        err       <= 1'b1;
                        dev_sel   <= '0;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign inst_ready     = (state == RESP) && !flushed;
    assign inst_bus_error = inst_ready && err;
    assign inst_stall     = inst_req && !inst_ready;

endmodule

// File: tb/tb_inst_bus_router.sv
// Directed, table-driven bench for inst_bus_router (two slaves, TIMEOUT=4).
// Each table row is one clock cycle of stimulus plus the outputs expected mid-cycle.
module tb_inst_bus_router;

    logic        clk;
    logic        rst_n;
    logic [31:0] mmu_output_address;
    logic        inst_req;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic        inst_bus_error;
    logic        inst_stall;
    logic [1:0]  dev_sel;
    logic [31:0] dev_address;
    logic [63:0] dev_rdata;
    logic [1:0]  dev_ack;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [1:0]  ack;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        exp_ready;
        logic        exp_err;
        logic [31:0] exp_data;
        logic        exp_stall;
        logic [1:0]  exp_sel;
        logic [31:0] exp_daddr;
    } vec_t;

    vec_t vecs[$];

    inst_bus_router #(
        .NUM_SLAVES (2),
        .DATA_W     (32),
        .SLAVE_BASE ({32'h1FC00000, 32'h00000000}),
        .SLAVE_MASK ({32'hFFF00000, 32'hFF800000}),
        .TIMEOUT    (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mmu_output_address (mmu_output_address),
        .inst_req           (inst_req),
        .inst_ready         (inst_ready),
        .inst_data          (inst_data),
        .inst_bus_error     (inst_bus_error),
        .inst_stall         (inst_stall),
        .dev_sel            (dev_sel),
        .dev_address        (dev_address),
        .dev_rdata          (dev_rdata),
        .dev_ack            (dev_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic req, input logic [31:0] addr, input logic [1:0] ack,
                                 input logic [31:0] rd0, input logic [31:0] rd1,
                                 input logic ready, input logic err, input logic [31:0] data,
                                 input logic stall, input logic [1:0] sel, input logic [31:0] daddr);
        vec_t v;
        v.req = req;          v.addr = addr;       v.ack = ack;
        v.rd0 = rd0;          v.rd1 = rd1;
        v.exp_ready = ready;  v.exp_err = err;     v.exp_data = data;
        v.exp_stall = stall;  v.exp_sel = sel;     v.exp_daddr = daddr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        inst_req           = v.req;
        mmu_output_address = v.addr;
        dev_ack            = v.ack;
        dev_rdata          = {v.rd1, v.rd0};
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkRow(input int row, input vec_t v);
        @(negedge clk);
        checkOutput($sformatf("row%0d inst_ready", row),     32'(inst_ready),     32'(v.exp_ready));
        checkOutput($sformatf("row%0d inst_bus_error", row), 32'(inst_bus_error), 32'(v.exp_err));
        checkOutput($sformatf("row%0d inst_stall", row),     32'(inst_stall),     32'(v.exp_stall));
        checkOutput($sformatf("row%0d dev_sel", row),        32'(dev_sel),        32'(v.exp_sel));
        checkOutput($sformatf("row%0d dev_address", row),    dev_address,         v.exp_daddr);
        if (v.exp_ready) begin
            checkOutput($sformatf("row%0d inst_data", row),  inst_data,           v.exp_data);
        end
    endtask

    localparam logic [31:0] RA = 32'hAAAA0000;
    localparam logic [31:0] RB = 32'hBBBB0000;

    initial begin
        bit got;
        int lat;

        rst_n              = 1'b0;
        inst_req           = 1'b0;
        mmu_output_address = '0;
        dev_ack            = '0;
        dev_rdata          = '0;

        // Unmapped address: error response one cycle after the request
        vecs.push_back(mkv(1, 32'h80000000, 2'b00, RA, RB, 0, 0, 0,            1, 2'b00, 32'h0));
        vecs.push_back(mkv(1, 32'h80000000, 2'b00, RA, RB, 1, 1, 0,            0, 2'b00, 32'h0));
        vecs.push_back(mkv(0, 32'h0,        2'b00, RA, RB, 0, 0, 0,            0, 2'b00, 32'h0));
        // Zero-wait SRAM fetch
        vecs.push_back(mkv(1, 32'h00000040, 2'b00, RA, RB, 0, 0, 0,            1, 2'b00, 32'h0));
        vecs.push_back(mkv(1, 32'h00000040, 2'b01, 32'h24020001, RB, 0, 0, 0,  1, 2'b01, 32'h40));
        vecs.push_back(mkv(1, 32'h00000040, 2'b00, RA, RB, 1, 0, 32'h24020001, 0, 2'b00, 32'h40));
        vecs.push_back(mkv(0, 32'h0,        2'b00, RA, RB, 0, 0, 0,            0, 2'b00, 32'h40));
        // Boot ROM with three wait states, address wobble and a stray slave-0 ack
        vecs.push_back(mkv(1, 32'h1FC00010, 2'b00, RA, RB, 0, 0, 0,            1, 2'b00, 32'h40));
        vecs.push_back(mkv(1, 32'h80000000, 2'b00, RA, RB, 0, 0, 0,            1, 2'b10, 32'h1FC00010));
        vecs.push_back(mkv(1, 32'h80000000, 2'b01, RA, RB, 0, 0, 0,            1, 2'b10, 32'h1FC00010));
        vecs.push_back(mkv(1, 32'h1FC00010, 2'b00, RA, RB, 0, 0, 0,            1, 2'b10, 32'h1FC00010));
        vecs.push_back(mkv(1, 32'h1FC00010, 2'b10, RA, 32'h3C08BFC0, 0, 0, 0,  1, 2'b10, 32'h1FC00010));
        vecs.push_back(mkv(1, 32'h1FC00010, 2'b00, RA, RB, 1, 0, 32'h3C08BFC0, 0, 2'b00, 32'h1FC00010));
        vecs.push_back(mkv(0, 32'h0,        2'b00, RA, RB, 0, 0, 0,            0, 2'b00, 32'h1FC00010));
        // Timeout on slave 0 with stray acks on slave 1
        vecs.push_back(mkv(1, 32'h00000100, 2'b00, RA, RB, 0, 0, 0,            1, 2'b00, 32'h1FC00010));
        vecs.push_back(mkv(1, 32'h00000100, 2'b10, RA, RB, 0, 0, 0,            1, 2'b01, 32'h100));
        vecs.push_back(mkv(1, 32'h00000100, 2'b10, RA, RB, 0, 0, 0,            1, 2'b01, 32'h100));
        vecs.push_back(mkv(1, 32'h00000100, 2'b00, RA, RB, 0, 0, 0,            1, 2'b01, 32'h100));
        vecs.push_back(mkv(1, 32'h00000100, 2'b10, RA, RB, 0, 0, 0,            1, 2'b01, 32'h100));
        vecs.push_back(mkv(1, 32'h00000100, 2'b00, RA, RB, 1, 1, 0,            0, 2'b00, 32'h100));
        vecs.push_back(mkv(0, 32'h0,        2'b00, RA, RB, 0, 0, 0,            0, 2'b00, 32'h100));
        // Flush: request dropped in WAIT, response swallowed, then a normal fetch
        vecs.push_back(mkv(1, 32'h00000200, 2'b00, RA, RB, 0, 0, 0,            1, 2'b00, 32'h100));
        vecs.push_back(mkv(0, 32'h00000200, 2'b00, RA, RB, 0, 0, 0,            0, 2'b01, 32'h200));
        vecs.push_back(mkv(0, 32'h00000200, 2'b01, 32'hDEADBEEF, RB, 0, 0, 0,  0, 2'b01, 32'h200));
        vecs.push_back(mkv(0, 32'h0,        2'b00, RA, RB, 0, 0, 0,            0, 2'b00, 32'h200));
        vecs.push_back(mkv(1, 32'h00000044, 2'b00, RA, RB, 0, 0, 0,            1, 2'b00, 32'h200));
        vecs.push_back(mkv(1, 32'h00000044, 2'b01, 32'h8C220000, RB, 0, 0, 0,  1, 2'b01, 32'h44));
        vecs.push_back(mkv(1, 32'h00000044, 2'b00, RA, RB, 1, 0, 32'h8C220000, 0, 2'b00, 32'h44));
        vecs.push_back(mkv(0, 32'h0,        2'b00, RA, RB, 0, 0, 0,            0, 2'b00, 32'h44));

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset inst_ready",     32'(inst_ready),     32'h0);
        checkOutput("reset inst_bus_error", 32'(inst_bus_error), 32'h0);
        checkOutput("reset dev_sel",        32'(dev_sel),        32'h0);
        checkOutput("reset dev_address",    dev_address,         32'h0);
        checkOutput("reset inst_data",      inst_data,           32'h0);
        checkOutput("reset inst_stall",     32'(inst_stall),     32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkRow(i, vecs[i]);
        end

        // Reset asserted while waiting on the boot ROM
        applyStimulus(mkv(1, 32'h1FC00020, 2'b00, RA, RB, 0, 0, 0, 1, 2'b00, 32'h44));
        checkRow(100, mkv(1, 32'h1FC00020, 2'b00, RA, RB, 0, 0, 0, 1, 2'b00, 32'h44));
        applyStimulus(mkv(1, 32'h1FC00020, 2'b00, RA, RB, 0, 0, 0, 1, 2'b10, 32'h1FC00020));
        checkRow(101, mkv(1, 32'h1FC00020, 2'b00, RA, RB, 0, 0, 0, 1, 2'b10, 32'h1FC00020));
        rst_n    = 1'b0;
        inst_req = 1'b0;
        #1;
        checkOutput("midreset inst_ready",     32'(inst_ready),     32'h0);
        checkOutput("midreset inst_bus_error", 32'(inst_bus_error), 32'h0);
        checkOutput("midreset dev_sel",        32'(dev_sel),        32'h0);
        checkOutput("midreset dev_address",    dev_address,         32'h0);
        checkOutput("midreset inst_data",      inst_data,           32'h0);
        checkOutput("midreset inst_stall",     32'(inst_stall),     32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("inreset inst_ready", 32'(inst_ready), 32'h0);
        rst_n = 1'b1;

        // Post-reset fetch from the boot ROM, bounded wait for the response
        @(posedge clk);
        #1;
        inst_req           = 1'b1;
        mmu_output_address = 32'h1FC00020;
        dev_ack            = 2'b00;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(posedge clk);
            #1;
            dev_ack   = (c == 1) ? 2'b10 : 2'b00;
            dev_rdata = {32'h0BF00000, RA};
            @(negedge clk);
            if (inst_ready) begin
                got = 1'b1;
                lat = c;
            end
        end
        checkOutput("postreset ready seen", 32'(got),            32'h1);
        checkOutput("postreset latency",    32'(lat),            32'h2);
        checkOutput("postreset inst_data",  inst_data,           32'h0BF00000);
        checkOutput("postreset error",      32'(inst_bus_error), 32'h0);
        @(posedge clk);
        #1;
        inst_req = 1'b0;
        dev_ack  = 2'b00;
        @(negedge clk);
        checkOutput("postreset idle ready", 32'(inst_ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
